// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the 8-bit restoring divider.
//   div_state_t : controller states IDLE -> RUN -> DONE -> IDLE
//   DIV_WIDTH   : operand/result width (the subtractor stage is fixed at 8 bits)
//   DIV_ITERS   : shift/subtract iterations per division
//   DIV_ZERO_Q  : quotient reported for a zero divisor
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int          DIV_WIDTH  = 8;
  localparam int          DIV_ITERS  = 8;
  localparam logic [7:0]  DIV_ZERO_Q = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : div_pkg

// File: rtl/full_subtractor_8bit.sv
// -----------------------------------------------------------------------------
// full_subtractor_8bit
// 8-bit ripple-borrow subtractor: diff = a - b - bin.
// Ports:
//   a, b  [7:0] in  : minuend / subtrahend
//   bin         in  : borrow in
//   diff  [7:0] out : difference (mod 256)
//   bout        out : borrow out (1 when a < b + bin)
// -----------------------------------------------------------------------------
module full_subtractor_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] diff,
  output logic       bout
);

  logic [8:0] borrow;

  // NOTE: every variable written in a combinational block gets a value on
  // every path (here by assigning all bits in order), so no latch is inferred.
  always_comb begin
    borrow[0] = bin;
    diff      = '0;
    for (int i = 0; i < 8; i++) begin
      diff[i]       = a[i] ^ b[i] ^ borrow[i];
      // Borrow ripples when the bit needs one (0-1) or when it is equal and
      // a borrow is already pending from below.
      borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end
  end

  assign bout = borrow[8];

endmodule : full_subtractor_8bit

// File: rtl/restoring_divider_8bit.sv
// -----------------------------------------------------------------------------
// restoring_divider_8bit
// Sequential unsigned restoring divider with start/done handshake. One trial
// subtraction per clock through full_subtractor_8bit; 8 iterations, done
// pulses 9 cycles after a start is accepted.
// Ports:
//   clk, rst          : clock (rising), asynchronous active-high reset
//   start             : request pulse, accepted only in IDLE
//   dividend, divisor : operands, captured on acceptance
//   busy              : high while an operation is in RUN or DONE
//   done              : one-cycle pulse when results become valid
//   quotient/remainder: results, held until the next accepted start
//   div_by_zero       : set with done when the captured divisor was 0
// Build option:
//   DIV_ZERO_FAST_EN  : when defined, a zero divisor skips the iterations and
//                       goes straight to DONE (1-cycle latency). Results and
//                       flag are identical either way.
// -----------------------------------------------------------------------------
module restoring_divider_8bit
  import div_pkg::*;
#(
  // Only 8 is supported: the subtractor stage is fixed at 8 bits.
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;        // partial remainder
  logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out / quotient in
  logic [WIDTH-1:0] d_q, d_d;        // captured divisor
  logic [3:0]       cnt_q, cnt_d;
  logic             zero_q, zero_d;  // captured divisor was zero
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // Trial subtraction of the shifted remainder against the divisor.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ok;

  assign shifted = {r_q, q_q[WIDTH-1]};

  full_subtractor_8bit u_sub (
    .a    (shifted[WIDTH-1:0]),
    .b    (d_q),
    .bin  (1'b0),
    .diff (diff),
    .bout (bout)
  );

  // With the 9th bit set the shifted value is >= 256 > D, so the trial always
  // succeeds and the low 8 bits of diff are already the exact difference.
  assign ok = shifted[WIDTH] | ~bout;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          cnt_d   = '0;
          zero_d  = (divisor == '0);
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef DIV_ZERO_FAST_EN
          // Preload exactly what the 8 iterations would leave behind.
          if (divisor == '0) begin
            r_d     = dividend;
            q_d     = DIV_ZERO_Q;
            state_d = DONE;
          end
`endif
        end
      end

      RUN: begin
        busy_d = 1'b1;
        if (ok) begin
          r_d = diff;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shifted[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITERS - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Outputs are registered, so busy stays high through the done cycle.
        busy_d      = 1'b1;
        done_d      = 1'b1;
        quotient_d  = q_q;
        remainder_d = r_q;
        dbz_d       = zero_q;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : restoring_divider_8bit

// File: tb/tb_restoring_divider_8bit.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider_8bit
// Self-checking bench for restoring_divider_8bit. Expected results come from
// plain integer division; expected latency is 9 cycles, or 1 for a zero
// divisor when DIV_ZERO_FAST_EN is defined.
// -----------------------------------------------------------------------------
module tb_restoring_divider_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 9;
`endif
  localparam int NORM_LAT = 9;

  restoring_divider_8bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: ordinary arithmetic, zero divisor mapped to FF / dividend.
  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z, output int lat);
    if (b == 8'd0) begin
      q = 8'hFF; r = a; z = 1'b1; lat = ZERO_LAT;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = NORM_LAT;
    end
  endfunction

  // Issue one operation and wait (bounded) for done. lat is the number of
  // rising edges after the accepting edge until done is seen; -1 on timeout.
  // Returns positioned at the negedge where done was observed.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [7:0] q,
                        output logic [7:0] r, output logic z);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom); divisor = 8'($urandom);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er, aq, ar;
    logic       ez, az;
    int         el, al;
    ref_div(a, b, eq, er, ez, el);
    run_op(a, b, al, aq, ar, az);
    checks++;
    if (al !== el) begin
      failures++;
      $display("FAIL %s latency %0d/%0d: got %0d expected %0d", name, a, b, al, el);
    end
    checks++;
    if (aq !== eq || ar !== er || az !== ez) begin
      failures++;
      $display("FAIL %s result %0d/%0d: got q=%0d r=%0d z=%0b expected q=%0d r=%0d z=%0b",
               name, a, b, aq, ar, az, eq, er, ez);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_in_done: got %b expected 1", name, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse_end: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d z=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] hq, hr;
    check_op("div_100_7", 8'd100, 8'd7);
    check_op("div_255_128", 8'd255, 8'd128);
    check_op("div_200_201", 8'd200, 8'd201);
    // Results must hold while idle with operands wiggling.
    hq = quotient; hr = remainder;
    repeat (4) begin
      @(negedge clk);
      dividend = 8'($urandom); divisor = 8'($urandom);
    end
    checks++;
    if (quotient !== 8'd0 || remainder !== 8'd200 || hq !== 8'd0 || hr !== 8'd200) begin
      failures++;
      $display("FAIL hold_results: got q=%0d r=%0d expected q=0 r=200", quotient, remainder);
    end
    check_op("div_255_1", 8'd255, 8'd1);
  endtask

  task automatic test_div_zero();
    check_op("div_37_0", 8'd37, 8'd0);
    check_op("div_0_0", 8'd0, 8'd0);
    // A following normal division must clear the flag.
    check_op("div_after_zero", 8'd9, 8'd4);
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      // Re-pulse 50/5 during RUN; must be neither used nor queued.
      if (c == 2) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== NORM_LAT || quotient !== 8'd14 || remainder !== 8'd2) begin
      failures++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d expected lat=9 q=14 r=2",
               lat, quotient, remainder);
    end
    // Nothing queued: no second done within a full operation time.
    lat = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) lat++;
    end
    checks++;
    if (lat != 0) begin
      failures++;
      $display("FAIL no_queued_start: got %0d extra done pulses expected 0", lat);
    end
    check_op("div_50_5", 8'd50, 8'd5);
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0 ||
        div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: got busy=%b done=%b q=%0d r=%0d z=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d done pulses busy=%b expected 0 0", seen, busy);
    end
    check_op("div_9_3", 8'd9, 8'd3);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 8'd0;
        1:       b = 8'($urandom_range(1, 3));
        2:       b = 8'($urandom_range(128, 255));
        default: b = 8'($urandom);
      endcase
      check_op("random", a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_start();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_restoring_divider_8bit
